// File: rtl/riscv_pkg.sv
// Shared decode constants and the ID/EX control bundle for the pipelined RV32 core.
package riscv_pkg;

  localparam int XLEN_C  = 32;
  localparam int REG_W_C = 5;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LW  = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef struct packed {
    logic [REG_W_C-1:0] rd;
    logic [XLEN_C-1:0]  rs1;
    logic [XLEN_C-1:0]  rs2;
    logic               wb_en;
    logic               wb_from_mem;
    logic               alu_rs2_reg;
    logic [XLEN_C-1:0]  imm;
    logic               add_en;
    logic               sub_en;
    logic               xor_en;
    logic               or_en;
    logic               and_en;
    logic               rs1_take_prev1;
    logic               rs2_take_prev1;
  } idex_ctrl_t;

  typedef struct packed {
    logic [REG_W_C-1:0] rd;
    logic               wb;
    logic               load;
  } hist_t;

  // A bubble is an add writing x0, so it doubles as the ID/EX reset value.
  localparam idex_ctrl_t BUBBLE = '{
    rd: 5'd0, rs1: 32'd0, rs2: 32'd0, wb_en: 1'b1, wb_from_mem: 1'b0,
    alu_rs2_reg: 1'b0, imm: 32'd0, add_en: 1'b1, sub_en: 1'b0, xor_en: 1'b0,
    or_en: 1'b0, and_en: 1'b0, rs1_take_prev1: 1'b0, rs2_take_prev1: 1'b0
  };

  function automatic logic [XLEN_C-1:0] sext12(input logic [11:0] v);
    return {{(XLEN_C-12){v[11]}}, v};
  endfunction

endpackage

// File: rtl/id_hazard_tracker.sv
// Two-deep issue history; flags prev1 forwarding and stalls on load-use and distance-2 hazards.
module id_hazard_tracker
  import riscv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_W_C-1:0] rs1_addr_i,
  input  logic [REG_W_C-1:0] rs2_addr_i,
  input  logic               rs1_use_i,
  input  logic               rs2_use_i,
  input  logic               issue_i,
  input  logic [REG_W_C-1:0] rd_i,
  input  logic               load_i,
  output logic               rs1_take_prev1_o,
  output logic               rs2_take_prev1_o,
  output logic               stall_o
);

  hist_t h1_q, h2_q, h1_d;
  logic  dep11_s, dep12_s, dep21_s, dep22_s;
  logic  stall1_s, stall2_s, stall_s;

  function automatic logic depends(input hist_t h, input logic [REG_W_C-1:0] a, input logic use_src);
    return use_src && h.wb && (h.rd != 5'd0) && (h.rd == a);
  endfunction

  // Hazard classification; h1 wins over h2 for the same operand.
  always_comb begin
    dep11_s  = depends(h1_q, rs1_addr_i, rs1_use_i);
    dep21_s  = depends(h2_q, rs1_addr_i, rs1_use_i);
    dep12_s  = depends(h1_q, rs2_addr_i, rs2_use_i);
    dep22_s  = depends(h2_q, rs2_addr_i, rs2_use_i);
    stall1_s = dep11_s ? h1_q.load : dep21_s;
    stall2_s = dep12_s ? h1_q.load : dep22_s;
    stall_s  = stall1_s | stall2_s;
    rs1_take_prev1_o = dep11_s & ~h1_q.load & ~stall_s;
    rs2_take_prev1_o = dep12_s & ~h1_q.load & ~stall_s;
    stall_o  = stall_s;
    if (issue_i && !stall_s) begin
      h1_d = '{rd: rd_i, wb: 1'b1, load: load_i};
    end else begin
      h1_d = '0;
    end
  end

  // History shift: h1 records what was actually issued this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h1_q <= '0;
      h2_q <= '0;
    end else begin
      h1_q <= h1_d;
      h2_q <= h1_q;
    end
  end

endmodule

// File: rtl/id_decode_issue.sv
// Decode/issue stage: decodes the RV32 ALU and lw subset and drives the ID/EX bundle.
module id_decode_issue
  import riscv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid_i,
  input  logic [31:0]           instr_i,
  output logic [REG_ADDR_W-1:0] rs1_addr_o,
  output logic [REG_ADDR_W-1:0] rs2_addr_o,
  input  logic [XLEN-1:0]       rs1_data_i,
  input  logic [XLEN-1:0]       rs2_data_i,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic [XLEN-1:0]       rs1_o,
  output logic [XLEN-1:0]       rs2_o,
  output logic                  writeback_en_o,
  output logic                  writeback_from_mem_o,
  output logic                  alu_rs2_reg_o,
  output logic [XLEN-1:0]       imm_o,
  output logic                  add_en_o,
  output logic                  sub_en_o,
  output logic                  xor_en_o,
  output logic                  or_en_o,
  output logic                  and_en_o,
  output logic                  rs1_take_prev1_o,
  output logic                  rs2_take_prev1_o,
  output logic                  stall_o,
  output logic                  illegal_o
);

  logic [6:0] opcode_s, f7_s;
  logic [2:0] f3_s;
  logic       legal_s, is_r_s, is_load_s, issue_s, use_rs2_s;
  logic       tp1_s, tp2_s, stall_s, illegal_q, illegal_d;
  idex_ctrl_t dec_s, out_s;

  assign opcode_s = instr_i[6:0];
  assign f3_s     = instr_i[14:12];
  assign f7_s     = instr_i[31:25];

  // Instruction decode into an un-gated control bundle.
  always_comb begin
    dec_s     = BUBBLE;
    dec_s.add_en = 1'b0;
    legal_s   = 1'b0;
    is_r_s    = 1'b0;
    is_load_s = 1'b0;
    case (opcode_s)
      OP_R: begin
        is_r_s = 1'b1;
        dec_s.alu_rs2_reg = 1'b1;
        if (f7_s == F7_BASE) begin
          case (f3_s)
            F3_ADD:  begin dec_s.add_en = 1'b1; legal_s = 1'b1; end
            F3_XOR:  begin dec_s.xor_en = 1'b1; legal_s = 1'b1; end
            F3_OR:   begin dec_s.or_en  = 1'b1; legal_s = 1'b1; end
            F3_AND:  begin dec_s.and_en = 1'b1; legal_s = 1'b1; end
            default: legal_s = 1'b0;
          endcase
        end else if (f7_s == F7_SUB && f3_s == F3_ADD) begin
          dec_s.sub_en = 1'b1;
          legal_s = 1'b1;
        end else begin
          legal_s = 1'b0;
        end
      end
      OP_IMM: begin
        dec_s.imm = sext12(instr_i[31:20]);
        case (f3_s)
          F3_ADD:  begin dec_s.add_en = 1'b1; legal_s = 1'b1; end
          F3_XOR:  begin dec_s.xor_en = 1'b1; legal_s = 1'b1; end
          F3_OR:   begin dec_s.or_en  = 1'b1; legal_s = 1'b1; end
          F3_AND:  begin dec_s.and_en = 1'b1; legal_s = 1'b1; end
          default: legal_s = 1'b0;
        endcase
      end
      OP_LOAD: begin
        dec_s.imm = sext12(instr_i[31:20]);
        if (f3_s == F3_LW) begin
          dec_s.add_en      = 1'b1;
          dec_s.wb_from_mem = 1'b1;
          is_load_s         = 1'b1;
          legal_s           = 1'b1;
        end else begin
          legal_s = 1'b0;
        end
      end
      default: legal_s = 1'b0;
    endcase
    dec_s.rd    = instr_i[11:7];
    dec_s.wb_en = 1'b1;
    dec_s.rs1   = rs1_data_i;
    dec_s.rs2   = is_r_s ? rs2_data_i : 32'd0;
  end

  assign issue_s   = instr_valid_i & legal_s;
  assign use_rs2_s = issue_s & is_r_s;

  id_hazard_tracker u_hazard (
    .clk              (clk),
    .rst              (rst),
    .rs1_addr_i       (instr_i[19:15]),
    .rs2_addr_i       (instr_i[24:20]),
    .rs1_use_i        (issue_s),
    .rs2_use_i        (use_rs2_s),
    .issue_i          (issue_s),
    .rd_i             (instr_i[11:7]),
    .load_i           (is_load_s),
    .rs1_take_prev1_o (tp1_s),
    .rs2_take_prev1_o (tp2_s),
    .stall_o          (stall_s)
  );

  // Reset, stalls, empty slots and illegal words all issue the bubble.
  always_comb begin
    if (rst || !issue_s || stall_s) begin
      out_s = BUBBLE;
    end else begin
      out_s = dec_s;
      out_s.rs1_take_prev1 = tp1_s;
      out_s.rs2_take_prev1 = tp2_s;
    end
    illegal_d = illegal_q | (instr_valid_i & ~legal_s);
  end

  // Sticky illegal-instruction flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign rs1_addr_o           = instr_i[19:15];
  assign rs2_addr_o           = instr_i[24:20];
  assign rd_addr_o            = out_s.rd;
  assign rs1_o                = out_s.rs1;
  assign rs2_o                = out_s.rs2;
  assign writeback_en_o       = out_s.wb_en;
  assign writeback_from_mem_o = out_s.wb_from_mem;
  assign alu_rs2_reg_o        = out_s.alu_rs2_reg;
  assign imm_o                = out_s.imm;
  assign add_en_o             = out_s.add_en;
  assign sub_en_o             = out_s.sub_en;
  assign xor_en_o             = out_s.xor_en;
  assign or_en_o              = out_s.or_en;
  assign and_en_o             = out_s.and_en;
  assign rs1_take_prev1_o     = out_s.rs1_take_prev1;
  assign rs2_take_prev1_o     = out_s.rs2_take_prev1;
  assign stall_o              = stall_s & ~rst;
  assign illegal_o            = illegal_q;

endmodule

// File: doc/id_decode_issue.md
Name: id_decode_issue

Overview:
Decode/issue stage of the pipelined RISC-V core. It is the producer side of the ID/EX pipeline register.
- Takes the IF/ID instruction and reads the register file.
- Decodes the ALU and load subset.
- Generates the ID/EX control bundle, including the prev1 forwarding flags.
- Keeps a two-deep history of issued instructions, used to detect load-use and distance-2 hazards, stall fetch and inject bubbles.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register address width.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; asynchronous, active-high.
- instr_valid_i  in  1  IF/ID holds a valid instruction.
- instr_i  in  32  instruction word from IF/ID.
- rs1_addr_o  out  5  register-file read address 1.
- rs2_addr_o  out  5  register-file read address 2.
- rs1_data_i  in  XLEN  register-file read data 1 (write-through, same-cycle writes visible).
- rs2_data_i  in  XLEN  register-file read data 2.
- rd_addr_o, rs1_o, rs2_o, writeback_en_o, writeback_from_mem_o, alu_rs2_reg_o, imm_o, add_en_o, sub_en_o, xor_en_o, or_en_o, and_en_o, rs1_take_prev1_o, rs2_take_prev1_o  out  5/XLEN/XLEN/1/1/1/XLEN/1/1/1/1/1/1/1  ID/EX inputs.
- stall_o  out  1  hold PC and IF/ID this cycle.
- illegal_o  out  1  sticky illegal-instruction flag.

Behaviour:
- Reset (async, while rst=1):
  - History h1 and h2 cleared: rd=0, wb=0, load=0.
  - illegal_o=0 and stall_o=0.
  - ID/EX outputs equal the bubble.
- Bubble: rd=0, rs1=rs2=imm=0, writeback_en=1, writeback_from_mem=0, alu_rs2_reg=0, add_en=1, all other enables=0, take_prev1 flags=0. This is the same encoding as the ID/EX reset value.
- Decode (combinational, zero latency):
  - opcode 0110011, funct7=0000000: f3 000 add, 100 xor, 110 or, 111 and. funct7=0100000 with f3 000: sub. Sets alu_rs2_reg=1.
  - opcode 0010011: f3 000 addi, 100 xori, 110 ori, 111 andi. Sets alu_rs2_reg=0 and imm=sext(instr[31:20]).
  - opcode 0000011, f3 010: lw. Sets add_en=1, alu_rs2_reg=0, imm=sext, writeback_from_mem=1.
  - All decoded instructions set writeback_en=1.
  - rs1_addr_o=instr[19:15] and rs2_addr_o=instr[24:20], always.
- Source use: rs1 is used by all decoded ops; rs2 only by R-type. A source of x0 never creates a dependency.
- Hazards: a source depends on hK when hK.wb=1, hK.rd!=0 and the addresses match. h1 takes priority over h2.
  - Depends on h1, h1 not a load: take_prev1=1 for that operand, no stall.
  - Depends on h1, h1 a load: stall.
  - Depends on h2 only: stall. There is no prev2 path; the operand is correct from the register file one cycle later.
- Stall cycle: stall_o=1, bubble driven, IF/ID and PC hold.
  - Hazards are re-evaluated every cycle.
  - A load-use hazard therefore costs exactly 2 bubbles; a distance-2 hazard costs 1.
- instr_valid_i=0: bubble issued, stall_o=0.
- Illegal (valid and undecodable): bubble issued, stall_o=0, illegal_o set.
  - illegal_o stays set until rst. Later instructions still issue.
- History update every cycle: h2<=h1; h1<=the entry actually issued this cycle.
  - A bubble or illegal instruction enters as rd=0, wb=0, load=0.
- Reset mid-stall: history is cleared, so the held instruction issues with no stall once reset is released.

Decomposition:
- riscv_pkg holds:
  - opcode constants OP_R, OP_IMM, OP_LOAD;
  - the funct3/funct7 constants;
  - a typedef for the ID/EX control bundle;
  - a BUBBLE constant of that type.
- Sub-module id_hazard_tracker holds the h1/h2 history registers and produces the take_prev1 flags and stall_o from the current sources.

Test Plan:
1. Assert rst asynchronously mid-cycle -> outputs are the bubble immediately (add_en=1, rd=0), stall_o=0, illegal_o=0.
2. 0x00500093 (addi x1,x0,5) then 0x00108133 (add x2,x1,x1) -> second instruction issues with rs1_take_prev1=1, rs2_take_prev1=1, stall_o=0.
3. 0x0000A183 (lw x3,0(x1)) then 0x00018233 (add x4,x3,x0) -> stall_o=1 for 2 cycles with two bubbles; then add issues with take_prev1=0 and rd_addr=4.
4. addi x1,x0,5; addi x5,x0,1; 0x00008133 (add x2,x1,x0) -> exactly 1 stall cycle before the add; take_prev1 flags=0.
5. 0x00500013 (addi x0,x0,5) then 0x00000333 (add x6,x0,x0) -> no forwarding, no stall.
6. 0xFFFFFFFF valid -> bubble, illegal_o=1 and held across a following legal addi (which issues normally), cleared only by rst.
